// File: rtl/pipe_ctrl_if.sv
// Decode inputs, hazard/flag inputs and staged control outputs of pipe_control_unit.
// master drives the decode stage and hazard controls; slave is the control unit.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ALUC_W = 4
);
  logic [6:0]        opcodeD;
  logic [2:0]        funct3D;
  logic [6:0]        funct7D;
  logic              StallE;
  logic              FlushE;
  logic              ZeroE;
  logic              LtE;
  logic              LtuE;
  logic [2:0]        ImmSrcD;
  logic              ALUSrcE;
  logic [ALUC_W-1:0] ALUControlE;
  logic              PCSrcE;
  logic [1:0]        ResultSrcE;
  logic              MemWriteM;
  logic [1:0]        MemStrobeM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcW;
  logic              IllegalW;
  logic [CNT_W-1:0]  IllegalCnt;

  modport master (
    output opcodeD, funct3D, funct7D, StallE, FlushE, ZeroE, LtE, LtuE,
    input  ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, ResultSrcE, MemWriteM, MemStrobeM,
    input  RegWriteW, ResultSrcW, IllegalW, IllegalCnt
  );

  modport slave (
    input  opcodeD, funct3D, funct7D, StallE, FlushE, ZeroE, LtE, LtuE,
    output ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, ResultSrcE, MemWriteM, MemStrobeM,
    output RegWriteW, ResultSrcW, IllegalW, IllegalCnt
  );
endinterface

// File: rtl/pipe_control_unit.sv
// RV32I pipelined control: combinational decode in D, registered control through E, M and W.
// Define RV32_ZMMUL_EN to decode mul/mulh/mulhsu/mulhu; otherwise funct7=0000001 is illegal.
module pipe_control_unit #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ALUC_W = 4
) (
  input logic          clk,
  input logic          rst,
  pipe_ctrl_if.slave   bus_io
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluSra  = 4'b1001;

  localparam logic [2:0] ImmFmtI = 3'b000;
  localparam logic [2:0] ImmFmtS = 3'b001;
  localparam logic [2:0] ImmFmtB = 3'b010;
  localparam logic [2:0] ImmFmtJ = 3'b011;
  localparam logic [2:0] ImmFmtU = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] mem_strobe;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] mem_strobe;
    logic       illegal;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_w_t;

  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = 4'b0000;
      3'b001:  op = 4'b0111;
      3'b010:  op = 4'b0101;
      3'b011:  op = 4'b0110;
      3'b100:  op = 4'b0100;
      3'b101:  op = 4'b1000;
      3'b110:  op = 4'b0011;
      default: op = 4'b0010;
    endcase
    return op;
  endfunction

  ctrl_e_t          dec, dec_d, e_q, e_d;
  ctrl_m_t          m_q, m_d;
  ctrl_w_t          w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal;
  logic [2:0]       imm_src;
  logic             taken;

  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    imm_src    = ImmFmtI;
    dec.funct3 = bus_io.funct3D;
    case (bus_io.opcodeD)
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = AluAdd;
        dec.mem_strobe = bus_io.funct3D[1:0];
        illegal        = (bus_io.funct3D[1:0] == 2'b11);
      end
      OpStore: begin
        dec.mem_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = AluAdd;
        dec.mem_strobe = bus_io.funct3D[1:0];
        imm_src        = ImmFmtS;
        illegal        = (bus_io.funct3D[1:0] == 2'b11);
      end
      OpReg: begin
        dec.reg_write = 1'b1;
        case (bus_io.funct7D)
          7'b0000000: dec.alu_ctrl = alu_base(bus_io.funct3D);
          7'b0100000: begin
            if (bus_io.funct3D == 3'b000)      dec.alu_ctrl = AluSub;
            else if (bus_io.funct3D == 3'b101) dec.alu_ctrl = AluSra;
            else                               illegal = 1'b1;
          end
`ifdef RV32_ZMMUL_EN
          // mul, mulh, mulhsu, mulhu occupy 1010..1101 in funct3 order
          7'b0000001: begin
            dec.alu_ctrl = 4'b1010 + {2'b00, bus_io.funct3D[1:0]};
            illegal      = bus_io.funct3D[2];
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OpImm: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_base(bus_io.funct3D);
        if (bus_io.funct3D == 3'b101 && bus_io.funct7D[5]) dec.alu_ctrl = AluSra;
      end
      OpBranch: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = AluSub;
        imm_src      = ImmFmtB;
        illegal      = (bus_io.funct3D[2:1] == 2'b01);
      end
      OpJal: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        imm_src        = ImmFmtJ;
      end
      OpJalr: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = AluAdd;
      end
      OpLui: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
        imm_src        = ImmFmtU;
      end
      OpAuipc: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = AluAdd;
        imm_src       = ImmFmtU;
      end
      default: illegal = 1'b1;
    endcase
  end

  // An illegal instruction travels as a bubble that carries only the illegal flag.
  always_comb begin
    dec_d = dec;
    if (illegal) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
    end
  end

  always_comb begin
    e_d = dec_d;
    m_d = '{reg_write: e_q.reg_write, result_src: e_q.result_src, mem_write: e_q.mem_write,
            mem_strobe: e_q.mem_strobe, illegal: e_q.illegal};
    w_d = '{reg_write: m_q.reg_write, result_src: m_q.result_src, illegal: m_q.illegal};
    if (bus_io.FlushE) begin
      e_d = '0;
    end else if (bus_io.StallE) begin
      e_d = e_q;
      m_d = '0;
    end
    cnt_d = cnt_q;
    if (w_q.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    case (e_q.funct3)
      3'b000:  taken = bus_io.ZeroE;
      3'b001:  taken = !bus_io.ZeroE;
      3'b100:  taken = bus_io.LtE;
      3'b101:  taken = !bus_io.LtE;
      3'b110:  taken = bus_io.LtuE;
      3'b111:  taken = !bus_io.LtuE;
      default: taken = 1'b0;
    endcase
  end

  assign bus_io.ImmSrcD     = imm_src;
  assign bus_io.ALUSrcE     = e_q.alu_src;
  assign bus_io.ALUControlE = ALUC_W'(e_q.alu_ctrl);
  assign bus_io.PCSrcE      = e_q.jump | (e_q.branch & taken);
  assign bus_io.ResultSrcE  = e_q.result_src;
  assign bus_io.MemWriteM   = m_q.mem_write;
  assign bus_io.MemStrobeM  = m_q.mem_strobe;
  assign bus_io.RegWriteW   = w_q.reg_write;
  assign bus_io.ResultSrcW  = w_q.result_src;
  assign bus_io.IllegalW    = w_q.illegal;
  assign bus_io.IllegalCnt  = cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: stimulus queues expected values per cycle,
// a negedge monitor compares whatever is due.
module tb_pipe_control_unit;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ALUC_W = 4;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBad    = 7'b1111111;

  localparam int SImm = 0, SAluSrc = 1, SAluCtl = 2, SPcSrc = 3, SMemWr = 4, SStrobe = 5;
  localparam int SRegWr = 6, SResW = 7, SResE = 8, SIllW = 9, SCnt = 10;

  typedef struct {
    int unsigned cyc;
    int          id;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        exp_q[$];

  pipe_ctrl_if #(.CNT_W(CNT_W), .ALUC_W(ALUC_W)) bus ();

  pipe_control_unit #(.CNT_W(CNT_W), .ALUC_W(ALUC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic string sig_name(input int id);
    case (id)
      SImm:    return "ImmSrcD";
      SAluSrc: return "ALUSrcE";
      SAluCtl: return "ALUControlE";
      SPcSrc:  return "PCSrcE";
      SMemWr:  return "MemWriteM";
      SStrobe: return "MemStrobeM";
      SRegWr:  return "RegWriteW";
      SResW:   return "ResultSrcW";
      SResE:   return "ResultSrcE";
      SIllW:   return "IllegalW";
      default: return "IllegalCnt";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int id);
    case (id)
      SImm:    return 32'(bus.ImmSrcD);
      SAluSrc: return 32'(bus.ALUSrcE);
      SAluCtl: return 32'(bus.ALUControlE);
      SPcSrc:  return 32'(bus.PCSrcE);
      SMemWr:  return 32'(bus.MemWriteM);
      SStrobe: return 32'(bus.MemStrobeM);
      SRegWr:  return 32'(bus.RegWriteW);
      SResW:   return 32'(bus.ResultSrcW);
      SResE:   return 32'(bus.ResultSrcE);
      SIllW:   return 32'(bus.IllegalW);
      default: return 32'(bus.IllegalCnt);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_at(input int unsigned c, input int id, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.id  = id;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        check($sformatf("%s@%0d", sig_name(exp_q[i].id), cyc), sample(exp_q[i].id),
              exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        check($sformatf("%s@%0d overdue", sig_name(exp_q[i].id), exp_q[i].cyc), 32'hdead,
              exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic lt, input logic ltu,
                       input logic st, input logic fl);
    bus.opcodeD = op;
    bus.funct3D = f3;
    bus.funct7D = f7;
    bus.ZeroE   = z;
    bus.LtE     = lt;
    bus.LtuE    = ltu;
    bus.StallE  = st;
    bus.FlushE  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    issue(op, f3, f7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop_flags(input logic z, input logic lt, input logic ltu);
    issue(OpImm, 3'b000, 7'b0, z, lt, ltu, 1'b0, 1'b0);
  endtask

  task automatic nop();
    nop_flags(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned k;
    int unsigned m;
    rst = 1'b1;
    bus.opcodeD = OpImm;
    bus.funct3D = 3'b000;
    bus.funct7D = 7'b0;
    bus.StallE  = 1'b0;
    bus.FlushE  = 1'b0;
    bus.ZeroE   = 1'b0;
    bus.LtE     = 1'b0;
    bus.LtuE    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset PCSrcE", 32'(bus.PCSrcE), 0);
    check("reset MemWriteM", 32'(bus.MemWriteM), 0);
    check("reset RegWriteW", 32'(bus.RegWriteW), 0);
    check("reset IllegalW", 32'(bus.IllegalW), 0);
    check("reset IllegalCnt", 32'(bus.IllegalCnt), 0);
    rst = 1'b0;

    // add x1,x2,x3
    k = cyc;
    expect_at(k + 1, SAluCtl, 4'b0000);
    expect_at(k + 1, SAluSrc, 0);
    expect_at(k + 3, SRegWr, 1);
    expect_at(k + 3, SResW, 2'b00);
    ins(OpReg, 3'b000, 7'b0000000);
    k = cyc; expect_at(k + 1, SAluCtl, 4'b0001);
    ins(OpReg, 3'b000, 7'b0100000);                       // sub
    k = cyc; expect_at(k, SImm, 3'b000); expect_at(k + 1, SAluCtl, 4'b1001);
    expect_at(k + 1, SAluSrc, 1);
    ins(OpImm, 3'b101, 7'b0100000);                       // srai
    k = cyc; expect_at(k + 1, SAluCtl, 4'b0110);
    ins(OpReg, 3'b011, 7'b0000000);                       // sltu
    k = cyc; expect_at(k + 1, SAluCtl, 4'b0011);
    ins(OpImm, 3'b110, 7'b0000000);                       // ori
    // lw
    k = cyc;
    expect_at(k + 1, SResE, 2'b01);
    expect_at(k + 1, SAluCtl, 4'b0000);
    expect_at(k + 2, SMemWr, 0);
    expect_at(k + 2, SStrobe, 2'b10);
    expect_at(k + 3, SRegWr, 1);
    expect_at(k + 3, SResW, 2'b01);
    ins(OpLoad, 3'b010, 7'b0);
    // sw, sh
    k = cyc; expect_at(k, SImm, 3'b001); expect_at(k + 2, SMemWr, 1);
    expect_at(k + 3, SRegWr, 0);
    ins(OpStore, 3'b010, 7'b0);
    k = cyc; expect_at(k + 2, SStrobe, 2'b01); expect_at(k + 2, SMemWr, 1);
    ins(OpStore, 3'b001, 7'b0);
    // lui, auipc, jal
    k = cyc; expect_at(k, SImm, 3'b100); expect_at(k + 3, SResW, 2'b11);
    ins(OpLui, 3'b000, 7'b0);
    k = cyc; expect_at(k + 1, SAluCtl, 4'b0000); expect_at(k + 1, SAluSrc, 1);
    expect_at(k + 3, SResW, 2'b00); expect_at(k + 3, SRegWr, 1);
    ins(OpAuipc, 3'b000, 7'b0);
    k = cyc; expect_at(k, SImm, 3'b011); expect_at(k + 1, SPcSrc, 1);
    expect_at(k + 3, SResW, 2'b10);
    ins(OpJal, 3'b000, 7'b0);
    nop();

    // Branches: flags are driven while the branch sits in E
    k = cyc; expect_at(k, SImm, 3'b010); expect_at(k + 1, SPcSrc, 1);
    ins(OpBranch, 3'b000, 7'b0); nop_flags(1'b1, 1'b0, 1'b0);       // beq taken
    k = cyc; expect_at(k + 1, SPcSrc, 0);
    ins(OpBranch, 3'b000, 7'b0); nop_flags(1'b0, 1'b0, 1'b0);       // beq not taken
    k = cyc; expect_at(k + 1, SPcSrc, 1);
    ins(OpBranch, 3'b110, 7'b0); nop_flags(1'b0, 1'b0, 1'b1);       // bltu taken
    k = cyc; expect_at(k + 1, SPcSrc, 0);
    ins(OpBranch, 3'b101, 7'b0); nop_flags(1'b0, 1'b1, 1'b0);       // bge not taken
    k = cyc; expect_at(k + 1, SPcSrc, 1);
    ins(OpBranch, 3'b001, 7'b0); nop_flags(1'b0, 1'b0, 1'b0);       // bne taken

    // Illegal encodings
    k = cyc; expect_at(k + 1, SPcSrc, 0); expect_at(k + 3, SIllW, 1);
    ins(OpBranch, 3'b010, 7'b0); nop_flags(1'b1, 1'b1, 1'b1);
    k = cyc; expect_at(k + 2, SMemWr, 0); expect_at(k + 3, SIllW, 1);
    expect_at(k + 3, SRegWr, 0);
    ins(OpLoad, 3'b011, 7'b0);
    k = cyc; expect_at(k + 3, SIllW, 1); expect_at(k + 3, SRegWr, 0);
    ins(OpReg, 3'b000, 7'b0000010);
    k = cyc;
`ifdef RV32_ZMMUL_EN
    expect_at(k + 1, SAluCtl, 4'b1010); expect_at(k + 3, SIllW, 0);
    expect_at(k + 3, SRegWr, 1);
`else
    expect_at(k + 3, SIllW, 1); expect_at(k + 3, SRegWr, 0);
`endif
    ins(OpReg, 3'b000, 7'b0000001);                       // mul
    k = cyc; expect_at(k + 3, SIllW, 0);
    ins(OpJal, 3'b000, 7'b0);

    // lw flushed out of E; then flush overriding stall on a sw
    k = cyc; expect_at(k + 1, SResE, 2'b00); expect_at(k + 2, SStrobe, 2'b00);
    expect_at(k + 3, SRegWr, 0);
    issue(OpLoad, 3'b010, 7'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    k = cyc; expect_at(k + 2, SMemWr, 0);
    issue(OpStore, 3'b010, 7'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    nop();

    // Stall holds add in E for an extra cycle and bubbles M
    k = cyc;
    expect_at(k + 1, SAluCtl, 4'b0000); expect_at(k + 2, SAluCtl, 4'b0000);
    expect_at(k + 3, SRegWr, 0); expect_at(k + 3, SAluCtl, 4'b0001);
    expect_at(k + 4, SRegWr, 1);
    ins(OpReg, 3'b000, 7'b0000000);
    issue(OpReg, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ins(OpReg, 3'b000, 7'b0100000);
    repeat (4) nop();

    // Counter saturation over 300 illegal instructions
    rst = 1'b1;
    #1;
    check("reset IllegalCnt mid-run", 32'(bus.IllegalCnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    k = cyc;
    expect_at(k + 3, SIllW, 1);
    expect_at(k + 3, SCnt, 0);
    expect_at(k + 4, SCnt, 1);
    expect_at(k + 103, SCnt, 100);
    expect_at(k + 257, SCnt, 254);
    expect_at(k + 258, SCnt, 255);
    expect_at(k + 259, SCnt, 255);
    expect_at(k + 302, SIllW, 1);
    expect_at(k + 303, SIllW, 0);
    expect_at(k + 303, SCnt, 255);
    expect_at(k + 320, SCnt, 255);
    repeat (300) ins(OpBad, 3'b000, 7'b0);
    repeat (25) nop();

    // Asynchronous reset with add in W, sw in M and jal in E
    ins(OpReg, 3'b000, 7'b0);
    ins(OpStore, 3'b010, 7'b0);
    ins(OpJal, 3'b000, 7'b0);
    bus.opcodeD = OpImm;
    bus.funct3D = 3'b000;
    bus.funct7D = 7'b0;
    #1;
    check("pre-rst RegWriteW", 32'(bus.RegWriteW), 1);
    check("pre-rst MemWriteM", 32'(bus.MemWriteM), 1);
    check("pre-rst PCSrcE", 32'(bus.PCSrcE), 1);
    #5;
    rst = 1'b1;
    #1;
    check("async rst MemWriteM", 32'(bus.MemWriteM), 0);
    check("async rst RegWriteW", 32'(bus.RegWriteW), 0);
    check("async rst PCSrcE", 32'(bus.PCSrcE), 0);
    check("async rst IllegalW", 32'(bus.IllegalW), 0);
    check("async rst IllegalCnt", 32'(bus.IllegalCnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m = cyc;
    expect_at(m, SRegWr, 0); expect_at(m + 1, SRegWr, 0); expect_at(m + 2, SRegWr, 0);
    expect_at(m, SMemWr, 0); expect_at(m + 1, SMemWr, 0); expect_at(m, SPcSrc, 0);
    expect_at(m + 3, SRegWr, 1);
    repeat (6) nop();

    foreach (exp_q[i]) begin
      check($sformatf("%s@%0d never compared", sig_name(exp_q[i].id), exp_q[i].cyc),
            32'hdead, exp_q[i].val);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
